// File: rtl/iobuf_reg_bank_pkg.sv
// Shared definitions for the bidirectional pad bank: direction state encoding,
// legal parameter ranges and the global tri-state override.
package iobuf_reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_RX      = 2'b00,
        ST_TURN_TX = 2'b01,
        ST_TX      = 2'b10,
        ST_TURN_RX = 2'b11
    } dir_state_e;

    localparam int TURN_CYCLES_MIN = 1;
    localparam int TURN_CYCLES_MAX = 15;
    localparam int IN_STAGES_MIN   = 1;
    localparam int IN_STAGES_MAX   = 4;

    // Global tri-state override shared by every I/O primitive; owned by the environment.
    logic glbl_gts_s = 1'b0;

    function automatic int clamp_int(input int value, input int lo, input int hi);
        int result;
        if (value < lo) begin
            result = lo;
        end else if (value > hi) begin
            result = hi;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/iobuf_in_capture.sv
// Input sampling pipeline for the pad bank; O_VALID only rises once every
// stage holds a sample taken while the bank was continuously receiving.
module iobuf_in_capture
    import iobuf_reg_bank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int IN_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad,
    input  logic             fill_en,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    localparam int          STAGES    = clamp_int(IN_STAGES, IN_STAGES_MIN, IN_STAGES_MAX);
    localparam logic [2:0]  FILL_FULL = 3'(STAGES);

    logic [WIDTH-1:0] pipe_r [STAGES];
    logic [2:0]       fill_r;
    logic [2:0]       fill_inc_s;
    logic             valid_r;

    // Pad sampling chain; runs every edge regardless of direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            pipe_r[0] <= pad;
            for (int i = 1; i < STAGES; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Saturating increment of the fill count.
    always_comb begin
        fill_inc_s = fill_r;
        if (fill_r == FILL_FULL) begin
            fill_inc_s = FILL_FULL;
        end else begin
            fill_inc_s = fill_r + 3'd1;
        end
    end

    // Fill tracking: any edge outside steady receive restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_r  <= 3'd0;
            valid_r <= 1'b0;
        end else if (fill_en) begin
            fill_r  <= fill_inc_s;
            valid_r <= (fill_inc_s == FILL_FULL);
        end else begin
            fill_r  <= 3'd0;
            valid_r <= 1'b0;
        end
    end

    assign o_data  = pipe_r[STAGES-1];
    assign o_valid = valid_r;

endmodule

// File: rtl/iobuf_reg_bank.sv
// WIDTH-bit bidirectional pad bank: direction FSM with guaranteed high-Z
// turnaround, registered drive data/enables and a multi-stage capture path.
module iobuf_reg_bank
    import iobuf_reg_bank_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int IN_STAGES   = 2
) (
    input  logic             C,
    input  logic             CLR,
    inout  wire  [WIDTH-1:0] IO,
    input  logic [WIDTH-1:0] I,
    input  logic [WIDTH-1:0] T,
    input  logic             DIR,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID,
    output logic             BUSY,
    output logic             TX_ACTIVE
);

    localparam logic [3:0] TURN_LOAD =
        4'(clamp_int(TURN_CYCLES, TURN_CYCLES_MIN, TURN_CYCLES_MAX) - 1);

    dir_state_e       state_r;
    dir_state_e       state_nxt_s;
    logic [3:0]       turn_cnt_r;
    logic [3:0]       turn_cnt_nxt_s;
    logic [WIDTH-1:0] oq_r;
    logic [WIDTH-1:0] oq_nxt_s;
    logic [WIDTH-1:0] tq_r;
    logic [WIDTH-1:0] tq_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             tx_active_r;
    logic             tx_active_nxt_s;
    logic             fill_en_s;
    logic [WIDTH-1:0] drive_en_s;

    // Direction state register.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_r <= ST_RX;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: DIR is only honoured in the steady states; turnarounds always run out.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RX: begin
                if (DIR) begin
                    state_nxt_s = ST_TURN_TX;
                end else begin
                    state_nxt_s = ST_RX;
                end
            end
            ST_TURN_TX: begin
                if (turn_cnt_r == 4'd0) begin
                    state_nxt_s = ST_TX;
                end else begin
                    state_nxt_s = ST_TURN_TX;
                end
            end
            ST_TX: begin
                if (!DIR) begin
                    state_nxt_s = ST_TURN_RX;
                end else begin
                    state_nxt_s = ST_TX;
                end
            end
            ST_TURN_RX: begin
                if (turn_cnt_r == 4'd0) begin
                    state_nxt_s = ST_RX;
                end else begin
                    state_nxt_s = ST_TURN_RX;
                end
            end
            default: begin
                state_nxt_s = ST_RX;
            end
        endcase
    end

    // Output decode: enables open only on edges that land in TX.
    always_comb begin
        oq_nxt_s        = oq_r;
        tq_nxt_s        = {WIDTH{1'b1}};
        turn_cnt_nxt_s  = turn_cnt_r;
        busy_nxt_s      = (state_nxt_s == ST_TURN_TX) || (state_nxt_s == ST_TURN_RX);
        tx_active_nxt_s = (state_nxt_s == ST_TX);
        fill_en_s       = (state_r == ST_RX) && (state_nxt_s == ST_RX);
        if (state_nxt_s == ST_TX) begin
            oq_nxt_s = I;
            tq_nxt_s = T;
        end else begin
            oq_nxt_s = oq_r;
            tq_nxt_s = {WIDTH{1'b1}};
        end
        // Steady states keep the counter preloaded so the first turnaround edge loads it.
        case (state_r)
            ST_RX, ST_TX: begin
                turn_cnt_nxt_s = TURN_LOAD;
            end
            ST_TURN_TX, ST_TURN_RX: begin
                if (turn_cnt_r == 4'd0) begin
                    turn_cnt_nxt_s = 4'd0;
                end else begin
                    turn_cnt_nxt_s = turn_cnt_r - 4'd1;
                end
            end
            default: begin
                turn_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // Registered drive data, enables, counter and status outputs.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            oq_r        <= {WIDTH{1'b0}};
            tq_r        <= {WIDTH{1'b1}};
            turn_cnt_r  <= 4'd0;
            busy_r      <= 1'b0;
            tx_active_r <= 1'b0;
        end else begin
            oq_r        <= oq_nxt_s;
            tq_r        <= tq_nxt_s;
            turn_cnt_r  <= turn_cnt_nxt_s;
            busy_r      <= busy_nxt_s;
            tx_active_r <= tx_active_nxt_s;
        end
    end

    assign drive_en_s = ~tq_r & {WIDTH{~glbl_gts_s}};

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign IO[g] = drive_en_s[g] ? oq_r[g] : 1'bz;
    end

    iobuf_in_capture #(
        .WIDTH     (WIDTH),
        .IN_STAGES (IN_STAGES)
    ) u_in_capture (
        .clk     (C),
        .rst     (CLR),
        .pad     (IO),
        .fill_en (fill_en_s),
        .o_data  (O),
        .o_valid (O_VALID)
    );

    assign BUSY      = busy_r;
    assign TX_ACTIVE = tx_active_r;

endmodule

// File: tb/tb_iobuf_reg_bank.sv
// Directed bench for iobuf_reg_bank: reset, turnarounds, per-bit masking,
// DIR glitch and the GTS/CLR overrides, with hand-computed expectations.
module tb_iobuf_reg_bank;

    logic       C;
    logic       CLR;
    logic [7:0] I;
    logic [7:0] T;
    logic       DIR;
    logic [7:0] O;
    logic       O_VALID;
    logic       BUSY;
    logic       TX_ACTIVE;
    wire  [7:0] io_w;
    logic [7:0] ext_en;
    logic [7:0] ext_val;

    int n_cmp  = 0;
    int n_fail = 0;

    // External agent on the pad bus; only drives while the bank should be high-Z.
    for (genvar k = 0; k < 8; k++) begin : g_ext
        assign io_w[k] = ext_en[k] ? ext_val[k] : 1'bz;
    end

    iobuf_reg_bank #(
        .WIDTH       (8),
        .TURN_CYCLES (2),
        .IN_STAGES   (2)
    ) dut (
        .C         (C),
        .CLR       (CLR),
        .IO        (io_w),
        .I         (I),
        .T         (T),
        .DIR       (DIR),
        .O         (O),
        .O_VALID   (O_VALID),
        .BUSY      (BUSY),
        .TX_ACTIVE (TX_ACTIVE)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge C);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        CLR     = 1'b1;
        DIR     = 1'b0;
        I       = 8'h00;
        T       = 8'hFF;
        ext_en  = 8'hFF;
        ext_val = 8'hA5;
        iobuf_reg_bank_pkg::glbl_gts_s = 1'b0;

        // Reset state while CLR held
        step(2);
        chk8("rst_O", O, 8'h00);
        chk1("rst_O_VALID", O_VALID, 1'b0);
        chk1("rst_BUSY", BUSY, 1'b0);
        chk1("rst_TX_ACTIVE", TX_ACTIVE, 1'b0);
        chk8("rst_IO_hiz", io_w, 8'hA5);
        CLR = 1'b0;

        // Idle receive: O valid at edge 2
        step(1);
        chk1("idle_e1_O_VALID", O_VALID, 1'b0);
        chk8("idle_e1_O", O, 8'h00);
        step(1);
        chk8("idle_e2_O", O, 8'hA5);
        chk1("idle_e2_O_VALID", O_VALID, 1'b1);
        chk8("idle_e2_IO_hiz", io_w, 8'hA5);

        // RX -> TX; external keeps driving the complement during turnaround
        DIR     = 1'b1;
        I       = 8'h3C;
        T       = 8'h00;
        ext_val = 8'hC3;
        step(1);
        chk1("tx_e0_BUSY", BUSY, 1'b1);
        chk1("tx_e0_TX_ACTIVE", TX_ACTIVE, 1'b0);
        chk1("tx_e0_O_VALID", O_VALID, 1'b0);
        chk8("tx_e0_IO_hiz", io_w, 8'hC3);
        step(1);
        chk1("tx_e1_BUSY", BUSY, 1'b1);
        chk1("tx_e1_TX_ACTIVE", TX_ACTIVE, 1'b0);
        chk8("tx_e1_IO_hiz", io_w, 8'hC3);
        ext_en = 8'h00;
        step(1);
        chk8("tx_e2_IO", io_w, 8'h3C);
        chk1("tx_e2_TX_ACTIVE", TX_ACTIVE, 1'b1);
        chk1("tx_e2_BUSY", BUSY, 1'b0);

        // One-cycle latency from I to pad
        I = 8'hA7;
        step(1);
        chk8("tx_latency_IO", io_w, 8'hA7);

        // Per-bit mask: low nibble released, external pulls it to 0
        I = 8'hFF;
        T = 8'h0F;
        step(1);
        ext_en  = 8'h0F;
        ext_val = 8'h00;
        #1;
        chk8("mask_IO", io_w, 8'hF0);

        // GTS override in TX
        ext_en = 8'h00;
        T      = 8'h00;
        step(1);
        chk8("gts_pre_IO", io_w, 8'hFF);
        iobuf_reg_bank_pkg::glbl_gts_s = 1'b1;
        ext_en  = 8'hFF;
        ext_val = 8'h00;
        #1;
        chk8("gts_async_IO", io_w, 8'h00);
        chk1("gts_async_TX_ACTIVE", TX_ACTIVE, 1'b1);
        I = 8'h5C;
        step(1);
        chk8("gts_edge_IO", io_w, 8'h00);
        chk1("gts_edge_TX_ACTIVE", TX_ACTIVE, 1'b1);
        chk1("gts_edge_BUSY", BUSY, 1'b0);
        iobuf_reg_bank_pkg::glbl_gts_s = 1'b0;
        ext_en = 8'h00;
        #1;
        chk8("gts_release_IO", io_w, 8'h5C);

        // TX -> RX
        DIR = 1'b0;
        step(1);
        ext_en  = 8'hFF;
        ext_val = 8'hA3;
        #1;
        chk8("rx_f0_IO_hiz", io_w, 8'hA3);
        chk1("rx_f0_TX_ACTIVE", TX_ACTIVE, 1'b0);
        chk1("rx_f0_BUSY", BUSY, 1'b1);
        step(1);
        chk1("rx_f1_BUSY", BUSY, 1'b1);
        chk1("rx_f1_O_VALID", O_VALID, 1'b0);
        chk8("rx_f1_IO_hiz", io_w, 8'hA3);
        step(1);
        chk1("rx_f2_BUSY", BUSY, 1'b0);
        chk1("rx_f2_TX_ACTIVE", TX_ACTIVE, 1'b0);
        chk1("rx_f2_O_VALID", O_VALID, 1'b0);
        ext_val = 8'h5A;
        step(1);
        chk1("rx_f3_O_VALID", O_VALID, 1'b0);
        step(1);
        chk1("rx_f4_O_VALID", O_VALID, 1'b1);
        chk8("rx_f4_O", O, 8'h5A);

        // DIR glitch: one-cycle pulse still yields full turnarounds and one TX cycle
        DIR     = 1'b1;
        I       = 8'h81;
        ext_val = 8'h7E;
        step(1);
        chk1("gl_g0_BUSY", BUSY, 1'b1);
        DIR = 1'b0;
        step(1);
        chk1("gl_g1_BUSY", BUSY, 1'b1);
        chk1("gl_g1_TX_ACTIVE", TX_ACTIVE, 1'b0);
        chk8("gl_g1_IO_hiz", io_w, 8'h7E);
        ext_en = 8'h00;
        step(1);
        chk1("gl_g2_TX_ACTIVE", TX_ACTIVE, 1'b1);
        chk1("gl_g2_BUSY", BUSY, 1'b0);
        chk8("gl_g2_IO", io_w, 8'h81);
        step(1);
        ext_en = 8'hFF;
        #1;
        chk1("gl_g3_TX_ACTIVE", TX_ACTIVE, 1'b0);
        chk1("gl_g3_BUSY", BUSY, 1'b1);
        chk8("gl_g3_IO_hiz", io_w, 8'h7E);
        step(1);
        chk1("gl_g4_BUSY", BUSY, 1'b1);
        chk1("gl_g4_TX_ACTIVE", TX_ACTIVE, 1'b0);
        step(1);
        chk1("gl_g5_BUSY", BUSY, 1'b0);
        chk1("gl_g5_TX_ACTIVE", TX_ACTIVE, 1'b0);

        // CLR in the middle of TX
        ext_en = 8'h00;
        DIR    = 1'b1;
        I      = 8'hC3;
        T      = 8'h00;
        step(3);
        chk8("clr_pre_IO", io_w, 8'hC3);
        chk1("clr_pre_TX_ACTIVE", TX_ACTIVE, 1'b1);
        CLR     = 1'b1;
        DIR     = 1'b0;
        ext_en  = 8'hFF;
        ext_val = 8'h3C;
        #1;
        chk8("clr_async_IO_hiz", io_w, 8'h3C);
        chk1("clr_async_TX_ACTIVE", TX_ACTIVE, 1'b0);
        chk1("clr_async_BUSY", BUSY, 1'b0);
        chk8("clr_async_O", O, 8'h00);
        chk1("clr_async_O_VALID", O_VALID, 1'b0);
        step(1);
        CLR = 1'b0;
        step(1);
        chk1("clr_r1_O_VALID", O_VALID, 1'b0);
        chk1("clr_r1_BUSY", BUSY, 1'b0);
        chk1("clr_r1_TX_ACTIVE", TX_ACTIVE, 1'b0);
        step(1);
        chk1("clr_r2_O_VALID", O_VALID, 1'b1);
        chk8("clr_r2_O", O, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
